// File: rtl/bp_pkg.sv
// Shared branch-prediction definitions: counter encoding, lookup-result struct,
// and the PC-to-index/tag helpers used by the BTB and the branch unit.
package bp_pkg;

    localparam int unsigned BP_PC_W = 32;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef struct packed {
        logic               match;
        logic [1:0]         ctr;
        logic [BP_PC_W-1:0] target;
    } bp_pred_t;

    localparam bp_pred_t BP_PRED_CLR = '{match: 1'b0, ctr: SNT, target: {BP_PC_W{1'b0}}};

    // Word index; the caller narrows the result to idx_w bits.
    function automatic logic [BP_PC_W-1:0] idx_of(input logic [BP_PC_W-1:0] pc,
                                                  input int unsigned      idx_w);
        logic [BP_PC_W-1:0] mask_v;
        mask_v = (BP_PC_W'(1) << idx_w) - BP_PC_W'(1);
        return (pc >> 2) & mask_v;
    endfunction

    function automatic logic [BP_PC_W-1:0] tag_of(input logic [BP_PC_W-1:0] pc,
                                                  input int unsigned      idx_w);
        return pc >> (idx_w + 32'd2);
    endfunction

endpackage

// File: rtl/bp_shadow_reg.sv
// One shadow pipeline stage for a BTB lookup result: flush clears, stall holds,
// otherwise the stage loads. Flush wins over stall.
import bp_pkg::*;

module bp_shadow_reg (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush_i,
    input  logic     stall_i,
    input  bp_pred_t d_i,
    output bp_pred_t q_o
);

    bp_pred_t q_q;
    bp_pred_t q_d;

    // Next-state selection for the stage.
    always_comb begin
        q_d = q_q;
        if (flush_i) begin
            q_d = BP_PRED_CLR;
        end else if (stall_i) begin
            q_d = q_q;
        end else begin
            q_d = d_i;
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= BP_PRED_CLR;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit counters: same-cycle prediction in IF, result
// carried through IF/ID and ID/EX shadow stages to the branch unit in EX.
import bp_pkg::*;

module branch_target_buffer #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned PC_W    = BP_PC_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] i_IF_PC,
    output logic            o_Pred_Taken,
    output logic [PC_W-1:0] o_Pred_NPC,
    input  logic            i_IFID_Stall,
    input  logic            i_IDEX_Stall,
    input  logic            i_Flush_IF_ID,
    input  logic            i_Flush_ID_EX,
    output logic            o_PcMatchValid,
    output logic [1:0]      o_CtrlIn,
    output logic [PC_W-1:0] o_Pred_Target_EX,
    input  logic            i_WriteEnable,
    input  logic [1:0]      i_CtrlOut,
    input  logic [PC_W-1:0] i_Upd_PC,
    input  logic [PC_W-1:0] i_Upd_Target
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx_s;
    logic [TAG_W-1:0] lk_tag_s;
    logic [IDX_W-1:0] up_idx_s;
    logic [TAG_W-1:0] up_tag_s;
    logic [PC_W-1:0]  pc_plus4_s;
    logic             hit_s;
    logic             upd_en_s;
    bp_pred_t         lookup_s;
    bp_pred_t         s1_s;
    bp_pred_t         s2_s;

    assign lk_idx_s   = IDX_W'(idx_of(i_IF_PC, IDX_W));
    assign lk_tag_s   = TAG_W'(tag_of(i_IF_PC, IDX_W));
    assign up_idx_s   = IDX_W'(idx_of(i_Upd_PC, IDX_W));
    assign up_tag_s   = TAG_W'(tag_of(i_Upd_PC, IDX_W));
    assign pc_plus4_s = i_IF_PC + PC_W'(4);
    assign upd_en_s   = i_WriteEnable & ~rst;

    // Lookup reads the arrays before this edge's update lands (read-before-write).
    always_comb begin
        hit_s    = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
        lookup_s = BP_PRED_CLR;
        if (hit_s) begin
            lookup_s.match  = 1'b1;
            lookup_s.ctr    = ctr_q[lk_idx_s];
            lookup_s.target = target_q[lk_idx_s];
        end else begin
            lookup_s.match  = 1'b0;
            lookup_s.ctr    = SNT;
            lookup_s.target = pc_plus4_s;
        end
    end

    assign o_Pred_Taken = lookup_s.match & lookup_s.ctr[1];
    assign o_Pred_NPC   = o_Pred_Taken ? lookup_s.target : pc_plus4_s;

    // Valid-bit next state: the update strobe sets the addressed entry.
    always_comb begin
        valid_d = valid_q;
        if (upd_en_s) begin
            valid_d[up_idx_s] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bits are the only array state cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= {ENTRIES{1'b0}};
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/target/counter payload, written verbatim from the branch unit.
    always_ff @(posedge clk) begin
        if (upd_en_s) begin
            tag_q[up_idx_s]    <= up_tag_s;
            target_q[up_idx_s] <= i_Upd_Target;
            ctr_q[up_idx_s]    <= i_CtrlOut;
        end
    end

    bp_shadow_reg u_s1 (
        .clk     (clk),
        .rst     (rst),
        .flush_i (i_Flush_IF_ID),
        .stall_i (i_IFID_Stall),
        .d_i     (lookup_s),
        .q_o     (s1_s)
    );

    bp_shadow_reg u_s2 (
        .clk     (clk),
        .rst     (rst),
        .flush_i (i_Flush_ID_EX),
        .stall_i (i_IDEX_Stall),
        .d_i     (s1_s),
        .q_o     (s2_s)
    );

    assign o_PcMatchValid   = s2_s.match;
    assign o_CtrlIn         = s2_s.ctr;
    assign o_Pred_Target_EX = s2_s.target;

endmodule
